data_mem_access_ctrl: RTL
=========================

// Module: data_mem_access_ctrl
// PURPOSE
// Sequences every access to the byte-addressed data RAM (4-byte word port, async read, sync write)
// and shares it between the CPU MEM stage and the debug unit. Implements LB/LBU/LH/LHU/LW and
// SB/SH/SW: loads slice and extend bytes, sub-word stores do a 2-step read-modify-write because
// the RAM always writes 4 bytes. Sits between the MEM stage / debug unit and the RAM instance.
// PARAMETERS
// ADDR_WIDTH    12  RAM byte-address width (4k bytes)
// DATA_WIDTH    8   RAM byte width; data word = 4*DATA_WIDTH = W (32)
// DBG_PRIORITY  1   1: debug wins simultaneous requests; 0: CPU wins
// PORTS
// i_clk           in   1           clock, all state on rising edge
// i_rst_n         in   1           asynchronous reset, active-low
// i_cpu_req       in   1           CPU access request, held until o_cpu_ack
// i_cpu_we        in   1           1 store, 0 load
// i_cpu_size      in   2           00 byte, 01 half, 11 word, 10 reserved
// i_cpu_unsigned  in   1           loads: 1 zero-extend, 0 sign-extend
// i_cpu_addr      in   ADDR_WIDTH  byte address
// i_cpu_wdata     in   W           store data, sub-word in low bits
// o_cpu_rdata     out  W           load result, valid while o_cpu_ack
// o_cpu_ack       out  1           1-cycle completion pulse
// o_cpu_err       out  1           1-cycle pulse with ack for size 10
// i_dbg_req       in   1           debug access request (word only), held until o_dbg_ack
// i_dbg_we        in   1           1 word write, 0 word read
// i_dbg_addr      in   ADDR_WIDTH  byte address
// i_dbg_wdata     in   W           write data
// o_dbg_rdata     out  W           read word, valid while o_dbg_ack
// o_dbg_ack       out  1           1-cycle completion pulse
// o_busy          out  1           state != IDLE
// o_ram_we        out  1           RAM write enable
// o_ram_addr      out  ADDR_WIDTH  RAM address
// o_ram_wdata     out  W           RAM write data
// i_ram_rdata     in   W           RAM async read data {addr+3..addr}
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, incl. o_ram_we, acks, err, rdata, ram addr/wdata.
// - FSM IDLE -> ACCESS -> (MERGE) -> IDLE. Access regs (addr, wdata, size, we, unsigned, owner)
//   load on IDLE exit; RAM outputs are driven from these regs only.
// - IDLE: arbitrate per DBG_PRIORITY; a req is ignored in the cycle its own ack is high.
//   Winner latched -> ACCESS. No req -> stay IDLE, o_ram_we=0.
// - ACCESS: o_ram_addr=latched addr. Load: register ack+rdata -> IDLE. Word store: o_ram_we=1,
//   wdata=latched word, register ack -> IDLE. Sub-word store: o_ram_we=0, capture i_ram_rdata into
//   merge reg -> MERGE. Size 10: no write, ack+err, rdata 0 -> IDLE.
// - MERGE: o_ram_we=1; wdata byte={m[31:8],wd[7:0]}, half={m[31:16],wd[15:0]}; ack -> IDLE.
// - Load data: byte rd[7:0], half rd[15:0], word rd; ext per i_cpu_unsigned. Debug always word.
// - Latency from accepting IDLE cycle C0: load/word store ack in C2 (write at end of C1);
//   sub-word store ack in C3 (write at end of C2). Acks/rdata are registered, high one cycle.
// - Ack cycle is IDLE: a pending other requester is accepted then (back-to-back, no bubble).
// - No alignment required; RAM addr+1..+3 wrap at top of space; RMW rewrites unchanged bytes.
// - Requests changing while ACCESS/MERGE have no effect (latched). Loser waits, req held.
// - Async reset mid-op: immediate IDLE, o_ram_we=0, no ack; RAM write of that op not guaranteed.
// TESTING
// - Debug SW 0x100=0xDEADBEEF, debug LW 0x100 -> dbg ack in C2, rdata 0xDEADBEEF
// - CPU SB 0x101=0x55 over 0x11223344 at 0x100 -> ack C3, word@0x100 = 0x11225544
// - CPU LB 0x103 (byte 0x80) signed -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x102 of 0x8001 -> 0xFFFF8001
// - CPU+debug req same cycle, DBG_PRIORITY=1 -> debug acked C2, CPU accepted in C2, acked C4
// - size 10 store -> ack+err pulse, RAM unchanged, rdata 0; assert o_ram_we never high
// - i_rst_n low during MERGE -> outputs 0 at once, IDLE after release, no ack issued

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// rtl/data_mem_access_ctrl.sv - shares the data RAM word port between CPU MEM stage and debug unit
module data_mem_access_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter bit DBG_PRIORITY = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cpu_req,
    input  logic                      i_cpu_we,
    input  logic [1:0]                i_cpu_size,
    input  logic                      i_cpu_unsigned,
    input  logic [ADDR_WIDTH-1:0]     i_cpu_addr,
    input  logic [4*DATA_WIDTH-1:0]   i_cpu_wdata,
    output logic [4*DATA_WIDTH-1:0]   o_cpu_rdata,
    output logic                      o_cpu_ack,
    output logic                      o_cpu_err,
    input  logic                      i_dbg_req,
    input  logic                      i_dbg_we,
    input  logic [ADDR_WIDTH-1:0]     i_dbg_addr,
    input  logic [4*DATA_WIDTH-1:0]   i_dbg_wdata,
    output logic [4*DATA_WIDTH-1:0]   o_dbg_rdata,
    output logic                      o_dbg_ack,
    output logic                      o_busy,
    output logic                      o_ram_we,
    output logic [ADDR_WIDTH-1:0]     o_ram_addr,
    output logic [4*DATA_WIDTH-1:0]   o_ram_wdata,
    input  logic [4*DATA_WIDTH-1:0]   i_ram_rdata
);
    localparam int W = 4 * DATA_WIDTH;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_MERGE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [W-1:0]          wdata_q;
    logic [W-1:0]          merge_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic                  dbg_own_q;
    logic                  cpu_cand, dbg_cand;
    logic                  grant_cpu, grant_dbg;
    logic [W-1:0]          merge_mask;
    logic [W-1:0]          merged;
    logic [W-1:0]          load_data;

    // A requester whose ack is visible this cycle is already served; ignore its still-held req.
    assign cpu_cand = i_cpu_req && !o_cpu_ack;
    assign dbg_cand = i_dbg_req && !o_dbg_ack;

    assign o_busy     = (state != ST_IDLE);
    assign o_ram_addr = addr_q;

    // Sub-word store overlays the new low byte/half on the word read back in ACCESS.
    assign merge_mask = (size_q == SZ_BYTE) ? {{(3*DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}}
                                            : {{(2*DATA_WIDTH){1'b0}}, {(2*DATA_WIDTH){1'b1}}};
    assign merged     = (merge_q & ~merge_mask) | (wdata_q & merge_mask);

    // Slice and extend the load result from the latched size and signedness.
    always_comb begin
        load_data = i_ram_rdata;
        case (size_q)
            SZ_BYTE: load_data = {{(W-DATA_WIDTH){!uns_q && i_ram_rdata[DATA_WIDTH-1]}},
                                  i_ram_rdata[DATA_WIDTH-1:0]};
            SZ_HALF: load_data = {{(W-2*DATA_WIDTH){!uns_q && i_ram_rdata[2*DATA_WIDTH-1]}},
                                  i_ram_rdata[2*DATA_WIDTH-1:0]};
            default: load_data = i_ram_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, arbitration and RAM write strobe/data.
    always_comb begin
        state_nxt   = state;
        grant_cpu   = 1'b0;
        grant_dbg   = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_wdata = wdata_q;
        case (state)
            ST_IDLE: begin
                if (cpu_cand && dbg_cand) begin
                    grant_dbg = DBG_PRIORITY;
                    grant_cpu = !DBG_PRIORITY;
                end else begin
                    grant_cpu = cpu_cand;
                    grant_dbg = dbg_cand;
                end
                if (grant_cpu || grant_dbg) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_IDLE;
                if (we_q && size_q == SZ_WORD) begin
                    o_ram_we = 1'b1;
                end else if (we_q && size_q != SZ_RSVD) begin
                    state_nxt = ST_MERGE;
                end
            end
            ST_MERGE: begin
                o_ram_we    = 1'b1;
                o_ram_wdata = merged;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Access registers latched on IDLE exit; RAM-side outputs come only from these.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_BYTE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            dbg_own_q <= 1'b0;
        end else if (grant_dbg) begin
            addr_q    <= i_dbg_addr;
            wdata_q   <= i_dbg_wdata;
            size_q    <= SZ_WORD;
            we_q      <= i_dbg_we;
            uns_q     <= 1'b0;
            dbg_own_q <= 1'b1;
        end else if (grant_cpu) begin
            addr_q    <= i_cpu_addr;
            wdata_q   <= i_cpu_wdata;
            size_q    <= i_cpu_size;
            we_q      <= i_cpu_we;
            uns_q     <= i_cpu_unsigned;
            dbg_own_q <= 1'b0;
        end
    end

    // Registered completion: one-cycle ack pulses, load data, and merge capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cpu_ack   <= 1'b0;
            o_cpu_err   <= 1'b0;
            o_dbg_ack   <= 1'b0;
            o_cpu_rdata <= '0;
            o_dbg_rdata <= '0;
            merge_q     <= '0;
        end else begin
            o_cpu_ack <= 1'b0;
            o_cpu_err <= 1'b0;
            o_dbg_ack <= 1'b0;
            if (state == ST_ACCESS) begin
                if (!dbg_own_q && size_q == SZ_RSVD) begin
                    o_cpu_ack   <= 1'b1;
                    o_cpu_err   <= 1'b1;
                    o_cpu_rdata <= '0;
                end else if (!we_q) begin
                    if (dbg_own_q) begin
                        o_dbg_ack   <= 1'b1;
                        o_dbg_rdata <= i_ram_rdata;
                    end else begin
                        o_cpu_ack   <= 1'b1;
                        o_cpu_rdata <= load_data;
                    end
                end else if (size_q == SZ_WORD) begin
                    o_dbg_ack <= dbg_own_q;
                    o_cpu_ack <= !dbg_own_q;
                end else begin
                    merge_q <= i_ram_rdata;
                end
            end else if (state == ST_MERGE) begin
                o_cpu_ack <= 1'b1;
            end
        end
    end
endmodule
